// File: rtl/usb_rx.sv
// FT232H synchronous-FIFO receive path: drives OE#/RD#, buffers bytes in a 4-entry FIFO, forwards to a downstream FIFO.
// Optional: define USB_RX_BYTE_CNT_EN to add the rx_byte_cnt output counting downstream writes.
module usb_rx (
  input  logic       usb_clk_60m,
  input  logic       rst_n,
  input  logic       usb_rxf_n,
  input  logic [7:0] usb_data_in,
  output logic       usb_oe_n,
  output logic       usb_rd_n,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_data_in,
  input  logic       full,
  input  logic       rx_enable,
  output logic       rx_busy
`ifdef USB_RX_BYTE_CNT_EN
  ,
  output logic [31:0] rx_byte_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    OE,
    READ,
    HOLD,
    END
  } state_t;

  state_t     state;
  state_t     state_d;
  logic       rxf_q;
  logic [7:0] data_q;
  logic       rd_q;
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;

  // A byte is on the bus one cycle after RD# was low while data was still available.
  assign push = !rd_q && !rxf_q;
  assign pop  = fifo_wr_en;

  assign fifo_wr_en   = (count != 3'd0) && !full;
  assign fifo_data_in = (count != 3'd0) ? mem[rd_ptr] : '0;
  assign rx_busy      = (state != IDLE) || (count != 3'd0);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (rx_enable && !rxf_q && count < 3'd2) state_d = OE;
      OE:   state_d = READ;
      READ: begin
        if (rxf_q || !rx_enable)  state_d = END;
        else if (count >= 3'd2)   state_d = HOLD;
      end
      HOLD: begin
        if (rxf_q || !rx_enable)  state_d = END;
        else if (count <= 3'd1)   state_d = READ;
      end
      END:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      usb_oe_n <= 1'b1;
      usb_rd_n <= 1'b1;
      rxf_q    <= 1'b1;
      data_q   <= '0;
      rd_q     <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_d;
      usb_oe_n <= !((state_d == OE) || (state_d == READ) || (state_d == HOLD));
      usb_rd_n <= (state_d != READ);
      rxf_q    <= usb_rxf_n;
      data_q   <= usb_data_in;
      rd_q     <= usb_rd_n;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge usb_clk_60m) begin
    if (push) mem[wr_ptr] <= data_q;
  end

`ifdef USB_RX_BYTE_CNT_EN
  always_ff @(posedge usb_clk_60m or negedge rst_n) begin
    if (!rst_n)          rx_byte_cnt <= '0;
    else if (fifo_wr_en) rx_byte_cnt <= rx_byte_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_usb_rx.sv
// Bench for usb_rx: FT232H bus model feeding queued bytes, scoreboard comparing downstream FIFO writes in bus order.
module tb_usb_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       usb_rxf_n;
  logic [7:0] usb_data_in;
  logic       usb_oe_n;
  logic       usb_rd_n;
  logic       fifo_wr_en;
  logic [7:0] fifo_data_in;
  logic       full;
  logic       rx_enable;
  logic       rx_busy;
`ifdef USB_RX_BYTE_CNT_EN
  logic [31:0] rx_byte_cnt;
`endif

  usb_rx dut (
    .usb_clk_60m (clk),
    .rst_n       (rst_n),
    .usb_rxf_n   (usb_rxf_n),
    .usb_data_in (usb_data_in),
    .usb_oe_n    (usb_oe_n),
    .usb_rd_n    (usb_rd_n),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .full        (full),
    .rx_enable   (rx_enable),
    .rx_busy     (rx_busy)
`ifdef USB_RX_BYTE_CNT_EN
    ,
    .rx_byte_cnt (rx_byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0] bus_q [$];
  logic [7:0] exp_q [$];
  bit  pend = 0;
  int  stall_pct = 0;
  int  consumed = 0;
  int  delivered = 0;
  int  wr_since_rst = 0;
  int  sc_wr = 0;
  int  max_occ = 0;
  bit  hold_seen = 0;
  bit  prev_rd_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Scoreboard monitor first, then the bus model, so both see the same sampled outputs.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      delivered++;
      sc_wr++;
      wr_since_rst++;
      if (exp_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
      else chk("wr_data", {24'd0, fifo_data_in}, {24'd0, exp_q.pop_front()});
    end
    if (!usb_oe_n && usb_rd_n && prev_rd_low) hold_seen = 1;
    prev_rd_low = !usb_rd_n;

    if (pend) begin
      if (bus_q.size() > 0) void'(bus_q.pop_front());
      consumed++;
    end
    usb_rxf_n   = (bus_q.size() == 0) || ($urandom_range(99) < stall_pct);
    usb_data_in = (bus_q.size() > 0) ? bus_q[0] : 8'($urandom);
    pend = !usb_rd_n && !usb_rxf_n && rst_n;
    if (consumed - delivered > max_occ) max_occ = consumed - delivered;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_bytes(input int n, input bit seq, input logic [7:0] start);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(start + 8'(i)) : 8'($urandom);
      bus_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic scenario_start();
    sc_wr = 0;
    consumed = 0;
    delivered = 0;
    max_occ = 0;
    hold_seen = 0;
  endtask

  // Wait until the DUT is idle and no further transfer can start, then drop bytes never read from the bus.
  task automatic quiesce(input string name);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < 5000) begin
      tick();
      n++;
      if (!rx_busy && (bus_q.size() == 0 || !rx_enable)) stable++;
      else stable = 0;
    end
    chk({name, "_quiesce"}, 32'(stable >= 3), 32'd1);
    while (bus_q.size() > 0) begin
      void'(bus_q.pop_back());
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    chk({name, "_all_delivered"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int rd_lows;
    rst_n = 1'b1;
    full = 1'b0;
    rx_enable = 1'b0;
    usb_rxf_n = 1'b1;
    usb_data_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_oe_n", usb_oe_n, 1);
    chk("rst_rd_n", usb_rd_n, 1);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_busy", rx_busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Eight sequential bytes, downstream always ready.
    scenario_start();
    rx_enable = 1'b1;
    add_bytes(8, 1'b1, 8'h01);
    n = 0;
    while (usb_oe_n && n < 50) begin tick(); n++; end
    chk("burst_oe_seen", usb_oe_n, 0);
    chk("burst_oe_before_rd", usb_rd_n, 1);
    tick();
    chk("burst_rd_low", usb_rd_n, 0);
    quiesce("burst");
    chk("burst_count", sc_wr, 8);
    chk("burst_idle_oe", usb_oe_n, 1);

    // Downstream full: buffer must fill to exactly four and park in HOLD.
    scenario_start();
    full = 1'b1;
    add_bytes(12, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) tick();
    chk("full_peak_occ", max_occ, 4);
    chk("full_hold_seen", hold_seen, 1);
    chk("full_no_wr", sc_wr, 0);
    full = 1'b0;
    quiesce("full");
    chk("full_count", sc_wr, 12);

    // Data runs out after five bytes: read stops with one END cycle.
    scenario_start();
    add_bytes(5, 1'b1, 8'hA0);
    n = 0;
    while (usb_rd_n && n < 50) begin tick(); n++; end
    while (!usb_rd_n && n < 100) begin tick(); n++; end
    chk("five_end_oe", usb_oe_n, 1);
    tick();
    chk("five_after_end_oe", usb_oe_n, 1);
    chk("five_after_end_rd", usb_rd_n, 1);
    quiesce("five");
    chk("five_count", sc_wr, 5);

    // rx_enable dropped mid-read: in-flight bytes kept, no further reads.
    scenario_start();
    add_bytes(40, 1'b0, 8'h00);
    n = 0;
    while (usb_rd_n && n < 50) begin tick(); n++; end
    tick(); tick(); tick();
    rx_enable = 1'b0;
    tick();
    chk("dis_end_rd", usb_rd_n, 1);
    chk("dis_end_oe", usb_oe_n, 1);
    rd_lows = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!usb_rd_n || !usb_oe_n) rd_lows++;
    end
    chk("dis_no_new_rd", rd_lows, 0);
    quiesce("dis");

    // Reset while reading with bytes buffered.
    scenario_start();
    rx_enable = 1'b1;
    full = 1'b1;
    add_bytes(20, 1'b0, 8'h00);
    n = 0;
    while (!((consumed - delivered) >= 2 && !usb_rd_n) && n < 100) begin tick(); n++; end
    chk("rst_mid_reached", 32'(n < 100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_oe_n", usb_oe_n, 1);
    chk("rstm_rd_n", usb_rd_n, 1);
    chk("rstm_wr_en", fifo_wr_en, 0);
    chk("rstm_busy", rx_busy, 0);
    bus_q.delete();
    exp_q.delete();
    rx_enable = 1'b0;
    full = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_since_rst = 0;
    sc_wr = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("rstm_no_wr", sc_wr, 0);

    // Randomised traffic: stalls on both sides, occasional enable drops.
    scenario_start();
    stall_pct = 20;
    rx_enable = 1'b1;
    add_bytes(300, 1'b0, 8'h00);
    n = 0;
    while (bus_q.size() > 0 && n < 20000) begin
      full = ($urandom_range(99) < 30);
      rx_enable = ($urandom_range(99) >= 5);
      tick();
      n++;
    end
    full = 1'b0;
    rx_enable = 1'b1;
    quiesce("rand");
    chk("rand_count", sc_wr, 300);
    chk("rand_max_occ_le4", 32'(max_occ <= 4), 1);
    chk("rand_since_rst", wr_since_rst, 300);
`ifdef USB_RX_BYTE_CNT_EN
    chk("byte_cnt", rx_byte_cnt, 300);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 SHALL have port usb_clk_60m  input  1  FT232H 60MHz clock; only clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port usb_rxf_n  input  1  FT232H RX data available flag, active low.
REQ-004 SHALL have port usb_data_in  input  8  FT232H data bus; top level owns the tri-state.
REQ-005 SHALL have port usb_oe_n  output  1  FT232H output enable, active low, registered.
REQ-006 SHALL have port usb_rd_n  output  1  FT232H read strobe, active low, registered.
REQ-007 SHALL have port fifo_wr_en  output  1  downstream FIFO write strobe.
REQ-008 SHALL have port fifo_data_in  output  8  downstream FIFO write data.
REQ-009 SHALL have port full  input  1  downstream FIFO full flag.
REQ-010 SHALL have port rx_enable  input  1  USB receive enable.
REQ-011 SHALL have port rx_busy  output  1  high whenever state is not IDLE or the buffer is not empty.

Function
REQ-012 SHALL register usb_rxf_n and usb_data_in in input flops (rxf_q, data_q) every edge.
REQ-013 SHALL keep rd_q, which is usb_rd_n delayed one cycle.
REQ-014 SHALL accept a byte at an edge iff the pre-edge values rd_q==0 and rxf_q==0; the accepted byte is data_q.
REQ-015 SHALL push accepted bytes into an internal 4-entry FIFO (buffer) with a 3-bit count.
REQ-016 SHALL use states IDLE, OE, READ, HOLD, END; encoding is free.
REQ-017 IDLE: oe_n=1, rd_n=1; go to OE when rx_enable && !rxf_q && count<2.
REQ-018 OE: oe_n=0, rd_n=1; go to READ after exactly one cycle, unconditionally.
REQ-019 READ: oe_n=0, rd_n=0; go to END if rxf_q || !rx_enable; else go to HOLD if count>=2; else stay.
REQ-020 HOLD: oe_n=0, rd_n=1; go to END if rxf_q || !rx_enable; else go to READ when count<=1.
REQ-021 END: oe_n=1, rd_n=1 for one bus-turnaround cycle, then go to IDLE.
REQ-022 SHALL make usb_oe_n/usb_rd_n the registered values of the next state (rd_n low only in READ, oe_n low in OE/READ/HOLD).
REQ-023 SHALL drive fifo_wr_en = (count!=0) && !full, with fifo_data_in = buffer head; on fifo_wr_en the head pops.
REQ-024 SHALL still accept in-flight bytes per REQ-014 after leaving READ; none are dropped.
REQ-025 SHALL never overflow the buffer; max occupancy is 4, reached with full held high.
REQ-026 Simultaneous push and pop: count unchanged; data order preserved.
REQ-027 SHALL never drop or duplicate a byte; FIFO output order equals bus order.
REQ-028 SHALL wrap buffer pointers modulo 4.

Reset
REQ-029 On rst_n low, outputs SHALL immediately become usb_oe_n=1, usb_rd_n=1, fifo_wr_en=0, fifo_data_in=0x00, rx_busy=0.
REQ-030 On rst_n low, state SHALL be IDLE; count, pointers and rd_q cleared; rxf_q set to 1; data_q set to 0.
REQ-031 Reset mid-READ SHALL discard buffered and in-flight bytes.

Configuration
REQ-032 With USB_RX_BYTE_CNT_EN defined, SHALL add output rx_byte_cnt[31:0] that counts fifo_wr_en pulses, wraps at 2^32 and resets to 0.
REQ-033 Without USB_RX_BYTE_CNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 rxf_n low for 8 bytes 0x01..0x08, full=0 -> OE one cycle before first RD low; FIFO receives 0x01..0x08 in order; END then IDLE.
REQ-035 Continuous rxf_n low, full=1 held -> RD toggles into HOLD, buffer count peaks at 4 with no overflow; full released -> all bytes delivered in order.
REQ-036 rxf_n rises mid-burst after 5 bytes -> exactly 5 bytes written; END lasts one cycle with oe_n=1.
REQ-037 rx_enable dropped during READ -> in-flight bytes written; no new RD low; IDLE within 2 cycles.
REQ-038 rst_n low during READ with 2 bytes buffered -> oe_n=rd_n=1 and fifo_wr_en=0 immediately; no writes after release until a new transfer.
REQ-039 With USB_RX_BYTE_CNT_EN, 300 bytes transferred -> rx_byte_cnt=300.
